// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, ALU op codes,
// sequencer state encoding and the decimal overflow limit.
package calc_pkg;

    localparam logic [3:0] KEY_9   = 4'd9;
    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ENT_A,
        ENT_B,
        EXEC,
        WAIT,
        SHOW,
        ERR
    } state_e;

    // 10**digits: the first value that no longer fits on the display.
    function automatic int unsigned calc_limit(input int unsigned digits);
        int unsigned l;
        l = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            l = l * 10;
        end
        return l;
    endfunction

    // Operator keys map onto the ALU op encoding in key order.
    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key, ALU and display signals of the calculator sequencer. The master side
// is the sequencer itself; the slave side is keypad decode, ALU and display.
interface calc_sequencer_if #(
    parameter int W = 16
);
    logic           key_valid;
    logic [3:0]     key_code;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [1:0]     alu_op;
    logic           alu_start;
    logic           alu_done;
    logic [2*W-1:0] alu_result;
    logic           alu_err;
    logic [W-1:0]   disp_val;
    logic           disp_err;
    logic           busy;

    modport master (
        input  key_valid, key_code, alu_done, alu_result, alu_err,
        output alu_a, alu_b, alu_op, alu_start, disp_val, disp_err, busy
    );

    modport slave (
        output key_valid, key_code, alu_done, alu_result, alu_err,
        input  alu_a, alu_b, alu_op, alu_start, disp_val, disp_err, busy
    );
endinterface

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator with digit counter. One instance serves both
// operands: the sequencer clears it when switching from A to B entry.
module calc_digit_acc #(
    parameter int DIGITS = 4,
    parameter int W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_digit_i,
    input  logic         append_digit_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] value_o,
    output logic [W-1:0] value_nxt_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next value: clear wins, then a fresh first digit, then append while room remains.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load_digit_i) begin
            value_d = W'(digit_i);
            cnt_d   = CW'(1);
        end else if (append_digit_i && (cnt_q < CW'(DIGITS))) begin
            // Cannot overflow W: only reached with at most DIGITS-1 digits held.
            value_d = value_q * W'(10) + W'(digit_i);
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Accumulator and digit count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value_o     = value_q;
    assign value_nxt_o = value_d;
    assign full_o      = (cnt_q == CW'(DIGITS));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Key-driven calculator sequencer: collects operands, drives the ALU with a
// start/done handshake, supports chained operators, owns the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    calc_sequencer_if.master bus
);

    localparam int unsigned    LIMIT    = calc_limit(DIGITS);
    localparam logic [2*W-1:0] LIMIT_W2 = (2*W)'(LIMIT);

    state_e       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [1:0]   op_q, op_d;
    logic [1:0]   next_op_q, next_op_d;
    logic         chain_q, chain_d;
    logic         abort_q, abort_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic [W-1:0] disp_q, disp_d, disp_base;
    logic         err_q, err_d;

    logic         acc_clr, acc_load, acc_app;
    logic [W-1:0] acc_val, acc_nxt;
    logic         acc_full, acc_empty;
    logic         go_exec, clear_all, b_nonempty;

    logic         key_dig, key_opr, key_eq, key_clr, ovf;
    logic [1:0]   key_opc;

    assign key_dig = bus.key_valid && (bus.key_code <= KEY_9);
    assign key_opr = bus.key_valid && (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);
    assign key_eq  = bus.key_valid && (bus.key_code == KEY_EQ);
    assign key_clr = bus.key_valid && (bus.key_code == KEY_CLR);
    assign key_opc = key_to_op(bus.key_code);
    assign ovf     = (bus.alu_result >= LIMIT_W2);

    // While in ENT_A the accumulator holds A; leaving ENT_A commits it to a_q and
    // the accumulator is reused for B.
    calc_digit_acc #(.DIGITS(DIGITS), .W(W)) u_acc (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (acc_clr),
        .load_digit_i   (acc_load),
        .append_digit_i (acc_app),
        .digit_i        (bus.key_code),
        .value_o        (acc_val),
        .value_nxt_o    (acc_nxt),
        .full_o         (acc_full),
        .empty_o        (acc_empty)
    );

    // Next-state and register updates driven by keys and ALU completion.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        op_d      = op_q;
        next_op_d = next_op_q;
        chain_d   = chain_q;
        abort_d   = abort_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        disp_base = disp_q;
        acc_clr   = 1'b0;
        acc_load  = 1'b0;
        acc_app   = 1'b0;
        go_exec   = 1'b0;
        clear_all = 1'b0;

        if (key_clr && (state_q != WAIT)) begin
            clear_all = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_dig) begin
                        acc_load = 1'b1;
                        state_d  = ENT_A;
                    end else if (key_opr) begin
                        a_d     = '0;
                        op_d    = key_opc;
                        acc_clr = 1'b1;
                        state_d = ENT_B;
                    end
                end
                ENT_A: begin
                    if (key_dig) begin
                        acc_app = !acc_full;
                    end else if (key_opr) begin
                        a_d     = acc_val;
                        op_d    = key_opc;
                        acc_clr = 1'b1;
                        state_d = ENT_B;
                    end else if (key_eq) begin
                        a_d       = acc_val;
                        disp_base = acc_val;
                        state_d   = SHOW;
                    end
                end
                ENT_B: begin
                    if (key_dig) begin
                        acc_app = !acc_full;
                    end else if (key_opr) begin
                        // With no B digits yet an operator just replaces the pending one.
                        if (acc_empty) begin
                            op_d = key_opc;
                        end else begin
                            chain_d   = 1'b1;
                            next_op_d = key_opc;
                            go_exec   = 1'b1;
                        end
                    end else if (key_eq) begin
                        chain_d = 1'b0;
                        go_exec = 1'b1;
                    end
                end
                EXEC: state_d = WAIT;
                WAIT: begin
                    // A CLR arriving with done counts as an abort; other keys are dropped.
                    if (bus.alu_done) begin
                        if (abort_q || key_clr) begin
                            clear_all = 1'b1;
                        end else if (bus.alu_err || ovf) begin
                            state_d = ERR;
                        end else if (chain_q) begin
                            a_d     = bus.alu_result[W-1:0];
                            op_d    = next_op_q;
                            chain_d = 1'b0;
                            acc_clr = 1'b1;
                            state_d = ENT_B;
                        end else begin
                            a_d       = bus.alu_result[W-1:0];
                            disp_base = bus.alu_result[W-1:0];
                            state_d   = SHOW;
                        end
                    end else if (key_clr) begin
                        abort_d = 1'b1;
                    end
                end
                SHOW: begin
                    if (key_dig) begin
                        acc_load = 1'b1;
                        state_d  = ENT_A;
                    end else if (key_opr) begin
                        op_d    = key_opc;
                        acc_clr = 1'b1;
                        state_d = ENT_B;
                    end
                end
                ERR:     ;
                default: clear_all = 1'b1;
            endcase
        end

        if (go_exec) begin
            alu_a_d = a_q;
            alu_b_d = acc_val;
            state_d = EXEC;
        end

        if (clear_all) begin
            state_d   = IDLE;
            a_d       = '0;
            op_d      = OP_ADD;
            next_op_d = OP_ADD;
            chain_d   = 1'b0;
            abort_d   = 1'b0;
            alu_a_d   = '0;
            alu_b_d   = '0;
            disp_base = '0;
            acc_clr   = 1'b1;
        end

        start_d = (state_d == EXEC);
        busy_d  = (state_d == EXEC) || (state_d == WAIT);
        err_d   = (state_d == ERR);
    end

    // Display value for the state being entered, so disp_val can be registered.
    always_comb begin
        b_nonempty = !acc_clr && (acc_app || acc_load || !acc_empty);
        case (state_d)
            IDLE, ERR: disp_d = '0;
            ENT_A:     disp_d = acc_nxt;
            ENT_B:     disp_d = b_nonempty ? acc_nxt : a_d;
            default:   disp_d = disp_base;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            op_q      <= OP_ADD;
            next_op_q <= OP_ADD;
            chain_q   <= 1'b0;
            abort_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            op_q      <= op_d;
            next_op_q <= next_op_d;
            chain_q   <= chain_d;
            abort_q   <= abort_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            disp_q    <= disp_d;
            err_q     <= err_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.disp_val  = disp_q;
    assign bus.disp_err  = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios then random keys, every cycle
// compared against a key-level calculator model; the bench also plays the ALU.
module tb_calc_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_sequencer_if #(.W(16)) bus();
    calc_sequencer #(.DIGITS(4), .W(16)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Calculator model, tracked per key in plain arithmetic.
    string m_mode;
    int m_a, m_acnt, m_b, m_bcnt, m_op, m_nop, m_chain, m_abort, m_disp, m_xa, m_xb;

    task automatic model_clear();
        m_mode = "IDLE";
        m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_op = 0; m_nop = 0;
        m_chain = 0; m_abort = 0; m_disp = 0; m_xa = 0; m_xb = 0;
    endtask

    task automatic model_exec();
        m_xa = m_a;
        m_xb = m_b;
        m_mode = "EXEC";
    endtask

    task automatic model_step(input bit kv, input int kc, input bit dn, input logic [31:0] res, input bit er);
        bit clr, dig, opk, eq;
        clr = kv && kc == 15;
        dig = kv && kc <= 9;
        opk = kv && kc >= 10 && kc <= 13;
        eq  = kv && kc == 14;
        if (m_mode == "WAIT") begin
            if (dn) begin
                if (m_abort != 0 || clr) model_clear();
                else if (er || res >= 32'd10000) m_mode = "ERR";
                else if (m_chain != 0) begin
                    m_a = int'(res); m_op = m_nop; m_b = 0; m_bcnt = 0; m_chain = 0; m_mode = "ENT_B";
                end else begin
                    m_a = int'(res); m_disp = int'(res); m_mode = "SHOW";
                end
            end else if (clr) m_abort = 1;
        end else if (clr) begin
            model_clear();
        end else if (m_mode == "EXEC") begin
            m_mode = "WAIT";
        end else if (m_mode == "IDLE") begin
            if (dig) begin m_a = kc; m_acnt = 1; m_mode = "ENT_A"; end
            else if (opk) begin m_a = 0; m_op = kc - 10; m_b = 0; m_bcnt = 0; m_mode = "ENT_B"; end
        end else if (m_mode == "ENT_A") begin
            if (dig) begin
                if (m_acnt < 4) begin m_a = m_a * 10 + kc; m_acnt++; end
            end else if (opk) begin m_op = kc - 10; m_b = 0; m_bcnt = 0; m_mode = "ENT_B"; end
            else if (eq) begin m_disp = m_a; m_mode = "SHOW"; end
        end else if (m_mode == "ENT_B") begin
            if (dig) begin
                if (m_bcnt < 4) begin m_b = m_b * 10 + kc; m_bcnt++; end
            end else if (opk) begin
                if (m_bcnt == 0) m_op = kc - 10;
                else begin m_chain = 1; m_nop = kc - 10; model_exec(); end
            end else if (eq) begin m_chain = 0; model_exec(); end
        end else if (m_mode == "SHOW") begin
            if (dig) begin m_a = kc; m_acnt = 1; m_mode = "ENT_A"; end
            else if (opk) begin m_op = kc - 10; m_b = 0; m_bcnt = 0; m_mode = "ENT_B"; end
        end
    endtask

    task automatic check_outputs();
        bool_chk: begin
            chk("busy",  32'(bus.busy),      32'(m_mode == "EXEC" || m_mode == "WAIT"));
            chk("start", 32'(bus.alu_start), 32'(m_mode == "EXEC"));
            chk("derr",  32'(bus.disp_err),  32'(m_mode == "ERR"));
        end
        if (m_mode == "IDLE" || m_mode == "ERR") chk("disp", 32'(bus.disp_val), 0);
        else if (m_mode == "ENT_A") chk("disp", 32'(bus.disp_val), m_a);
        else if (m_mode == "ENT_B") chk("disp", 32'(bus.disp_val), m_bcnt > 0 ? m_b : m_a);
        else if (m_mode == "SHOW") chk("disp", 32'(bus.disp_val), m_disp);
        if (m_mode == "EXEC" || m_mode == "WAIT") begin
            chk("alu_a", 32'(bus.alu_a), m_xa);
            chk("alu_b", 32'(bus.alu_b), m_xb);
        end
        if (m_mode == "EXEC" || m_mode == "WAIT" || m_mode == "ENT_B")
            chk("alu_op", 32'(bus.alu_op), m_op);
    endtask

    // One clock: drive at the falling edge, let the rising edge act, check at the next fall.
    task automatic cycle(input bit kv, input int kc, input bit dn, input logic [31:0] res, input bit er);
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        bus.alu_done   = dn;
        bus.alu_result = res;
        bus.alu_err    = er;
        @(posedge clk);
        model_step(kv, kc, dn, res, er);
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.alu_done  = 1'b0;
        check_outputs();
    endtask

    task automatic key(input int kc);        cycle(1'b1, kc, 1'b0, 32'd0, 1'b0); endtask
    task automatic idle();                   cycle(1'b0, 0, 1'b0, 32'd0, 1'b0);  endtask
    task automatic done(input int unsigned r, input bit e); cycle(1'b0, 0, 1'b1, r, e); endtask

    task automatic keys(input int ks[]);
        foreach (ks[i]) key(ks[i]);
    endtask

    task automatic alu_calc(output logic [31:0] r, output bit e);
        e = 1'b0;
        r = 32'd0;
        case (m_op)
            0: r = 32'(m_xa + m_xb);
            1: if (m_xa < m_xb) e = 1'b1; else r = 32'(m_xa - m_xb);
            2: r = 32'(m_xa) * 32'(m_xb);
            default: if (m_xb == 0) e = 1'b1; else r = 32'(m_xa / m_xb);
        endcase
    endtask

    task automatic pick_key(output bit kv, output int kc);
        int x;
        kv = 1'b0;
        kc = 0;
        if ($urandom_range(0, 1) == 1) begin
            kv = 1'b1;
            x = int'($urandom_range(0, 99));
            if (x < 60)      kc = int'($urandom_range(0, 9));
            else if (x < 82) kc = int'($urandom_range(10, 13));
            else if (x < 96) kc = 14;
            else             kc = 15;
        end
    endtask

    initial begin
        int wcnt;
        string prev;
        rst = 1'b1;
        bus.key_valid = 1'b0; bus.key_code = 4'd0;
        bus.alu_done = 1'b0; bus.alu_result = 32'd0; bus.alu_err = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_disp",  32'(bus.disp_val),  0);
        chk("rst_busy",  32'(bus.busy),      0);
        chk("rst_start", 32'(bus.alu_start), 0);
        chk("rst_derr",  32'(bus.disp_err),  0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add.
        keys('{1, 2, 10, 3, 4, 14});
        chk("t1_a", 32'(bus.alu_a), 12);
        chk("t1_b", 32'(bus.alu_b), 34);
        chk("t1_op", 32'(bus.alu_op), 0);
        chk("t1_start", 32'(bus.alu_start), 1);
        idle();
        chk("t1_start_off", 32'(bus.alu_start), 0);
        done(46, 1'b0);
        chk("t1_disp", 32'(bus.disp_val), 46);

        // Fifth digit ignored.
        keys('{15, 1, 2, 3, 4, 5});
        chk("t2_disp", 32'(bus.disp_val), 1234);

        // Chained operator.
        keys('{15, 5, 12, 6, 11});
        chk("t3_op_exec", 32'(bus.alu_op), 2);
        idle();
        done(30, 1'b0);
        chk("t3_op_chain", 32'(bus.alu_op), 1);
        chk("t3_disp", 32'(bus.disp_val), 30);

        // Divide by zero, error is sticky until CLR.
        keys('{15, 8, 13, 0, 14});
        idle();
        done(0, 1'b1);
        chk("t4_err", 32'(bus.disp_err), 1);
        key(7);
        chk("t4_err_hold", 32'(bus.disp_err), 1);
        key(15);
        chk("t4_clr_disp", 32'(bus.disp_val), 0);

        // Overflow boundary.
        keys('{9, 9, 9, 9, 12, 9, 9, 9, 9, 14});
        idle();
        done(99980001, 1'b0);
        chk("t5_ovf", 32'(bus.disp_err), 1);
        keys('{15, 9, 9, 9, 9, 10, 0, 14});
        idle();
        done(9999, 1'b0);
        chk("t5_max_ok", 32'(bus.disp_val), 9999);
        keys('{15, 9, 9, 9, 9, 10, 1, 14});
        idle();
        done(10000, 1'b0);
        chk("t5_limit", 32'(bus.disp_err), 1);

        // Abort during WAIT.
        keys('{15, 1, 10, 2, 14});
        idle();
        key(15);
        chk("t5_abort_busy", 32'(bus.busy), 1);
        idle();
        done(3, 1'b0);
        chk("t5_abort_busy_off", 32'(bus.busy), 0);
        chk("t5_abort_disp", 32'(bus.disp_val), 0);

        // Done with a digit in the same cycle, then a stray done.
        keys('{3, 10, 4, 14});
        idle();
        cycle(1'b1, 7, 1'b1, 32'd7, 1'b0);
        chk("t_sim_disp", 32'(bus.disp_val), 7);
        cycle(1'b0, 0, 1'b1, 32'd55, 1'b0);
        chk("t_stray_disp", 32'(bus.disp_val), 7);

        // Asynchronous reset in the middle of B entry.
        keys('{1, 11, 2});
        #2 rst = 1'b1;
        #1;
        chk("t6_disp",  32'(bus.disp_val), 0);
        chk("t6_op",    32'(bus.alu_op),   0);
        chk("t6_busy",  32'(bus.busy),     0);
        chk("t6_alu_a", 32'(bus.alu_a),    0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        key(4);
        chk("t6_after", 32'(bus.disp_val), 4);

        // Random keys with the bench acting as the ALU.
        wcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit kv, dn, e;
            int kc;
            logic [31:0] r;
            dn = 1'b0; e = 1'b0; r = 32'd0;
            pick_key(kv, kc);
            if (m_mode == "WAIT") begin
                if (wcnt == 0) begin dn = 1'b1; alu_calc(r, e); end
                else wcnt--;
            end else if ($urandom_range(0, 29) == 0) begin
                dn = 1'b1;
                r = 32'($urandom_range(0, 20000));
            end
            prev = m_mode;
            cycle(kv, kc, dn, r, e);
            if (m_mode == "WAIT" && prev != "WAIT") wcnt = int'($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
